power_seq_ctrl: RTL

Parametrised power-rail sequencer with debounced power-key handling, placed beside the top-level power and backlight logic. It replaces the fixed single-rail delayed enable with N ordered rail enables: staggered turn-on, reverse-order turn-off, long-press and ARM-requested shutdown, and latched per-rail fault cut-off. It also exports the debounced key level to the ARM.

---
 rtl/power_seq_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/power_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : power_seq_ctrl
// Brief   : N-rail power sequencer with debounced key, long-press/ARM shutdown
//           and latched per-rail fault cut-off.
// Revision: 1.0  initial release
// ============================================================================
module power_seq_ctrl #(
  parameter int N_RAIL     = 4,
  parameter int TICK_DIV   = 100000,
  parameter int CNT_W      = 16,
  parameter int ON_GAP_MS  = 2000,
  parameter int OFF_GAP_MS = 50,
  parameter int DEB_MS     = 20,
  parameter int LONG_MS    = 2000
) (
  input  logic              clk_sys,
  input  logic              RESET_IN,
  input  logic              key_det,
  input  logic [N_RAIL-1:0] fault_n,
  input  logic              arm_off_req,
  output logic [N_RAIL-1:0] rail_en,
  output logic              key_det_arm,
  output logic [N_RAIL-1:0] fault_latched,
  output logic [2:0]        seq_state,
  output logic              busy
);

  localparam int                 c_pre_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   c_deb     = CNT_W'(DEB_MS);
  localparam logic [CNT_W-1:0]   c_long    = CNT_W'(LONG_MS);
  localparam logic [CNT_W-1:0]   c_on_gap  = CNT_W'(ON_GAP_MS);
  localparam logic [CNT_W-1:0]   c_off_gap = CNT_W'(OFF_GAP_MS);

  localparam logic [2:0] c_st_off   = 3'd0;
  localparam logic [2:0] c_st_up    = 3'd1;
  localparam logic [2:0] c_st_on    = 3'd2;
  localparam logic [2:0] c_st_down  = 3'd3;
  localparam logic [2:0] c_st_fault = 3'd4;

  logic              r_key_s1, r_key_s2, r_key_arm_d;
  logic [N_RAIL-1:0] r_flt_s1, r_flt_s2;
  logic [c_pre_w-1:0] r_deb_pre, r_seq_pre;
  logic [CNT_W-1:0]  r_deb_cnt, r_hold_cnt, r_gap_cnt;
  logic [2:0]        r_state, w_state_nxt;
  logic [N_RAIL-1:0] w_rail_nxt, w_latch_nxt, w_flt, w_up_step, w_dn_step;
  logic [CNT_W-1:0]  w_gap_lim;
  logic              w_deb_tick, w_seq_tick, w_press, w_long_hit, w_gap_hit;
  logic              w_flt_any, w_seq_clr, w_active;

  always_ff @(posedge clk_sys or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_key_s1 <= 1'b0;
      r_key_s2 <= 1'b0;
      r_flt_s1 <= {N_RAIL{1'b1}};
      r_flt_s2 <= {N_RAIL{1'b1}};
    end else begin
      r_key_s1 <= key_det;
      r_key_s2 <= r_key_s1;
      r_flt_s1 <= fault_n;
      r_flt_s2 <= r_flt_s1;
    end
  end

  assign w_deb_tick = (r_deb_pre == c_pre_max);
  assign w_press    = key_det_arm & ~r_key_arm_d;
  assign w_long_hit = (r_hold_cnt >= c_long);

  // A level is only accepted after DEB_MS whole tick intervals of stability.
  always_ff @(posedge clk_sys or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_deb_pre   <= '0;
      r_deb_cnt   <= '0;
      key_det_arm <= 1'b0;
      r_key_arm_d <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_deb_pre   <= w_deb_tick ? '0 : r_deb_pre + 1'b1;
      r_key_arm_d <= key_det_arm;
      if (r_key_s2 == key_det_arm) begin
        r_deb_cnt <= '0;
      end else if (w_deb_tick) begin
        if (r_deb_cnt >= c_deb) begin
          key_det_arm <= r_key_s2;
          r_deb_cnt   <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + 1'b1;
        end
      end
      if ((r_state == c_st_on) && key_det_arm) begin
        if (w_deb_tick && (r_hold_cnt < c_long))
          r_hold_cnt <= r_hold_cnt + 1'b1;
      end else begin
        r_hold_cnt <= '0;
      end
    end
  end

  // Sequence timer restarts on every state change or rail step for exact gaps.
  assign w_seq_tick = (r_seq_pre == c_pre_max);
  assign w_gap_lim  = (r_state == c_st_up) ? c_on_gap : c_off_gap;
  assign w_gap_hit  = w_seq_tick && (({1'b0, r_gap_cnt} + (CNT_W+1)'(1)) >= {1'b0, w_gap_lim});
  assign w_seq_clr  = (w_state_nxt != r_state) || (w_rail_nxt != rail_en);

  always_ff @(posedge clk_sys or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_seq_pre <= '0;
      r_gap_cnt <= '0;
    end else if (w_seq_clr) begin
      r_seq_pre <= '0;
      r_gap_cnt <= '0;
    end else if (w_seq_tick) begin
      r_seq_pre <= '0;
      if (r_gap_cnt != c_cnt_max)
        r_gap_cnt <= r_gap_cnt + 1'b1;
    end else begin
      r_seq_pre <= r_seq_pre + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_state       <= c_st_off;
      rail_en       <= '0;
      fault_latched <= '0;
    end else begin
      r_state       <= w_state_nxt;
      rail_en       <= w_rail_nxt;
      fault_latched <= w_latch_nxt;
    end
  end

  assign w_flt     = ~r_flt_s2 & rail_en;
  assign w_flt_any = |w_flt;
  assign w_up_step = (rail_en << 1) | N_RAIL'(1);
  assign w_dn_step = rail_en >> 1;
  assign w_active  = (r_state == c_st_up) || (r_state == c_st_on) || (r_state == c_st_down);

  always_comb begin
    w_state_nxt = r_state;
    w_rail_nxt  = rail_en;
    w_latch_nxt = fault_latched;
    if (w_active && w_flt_any) begin
      w_state_nxt = c_st_fault;
      w_rail_nxt  = '0;
      w_latch_nxt = fault_latched | w_flt;
    end else begin
      case (r_state)
        c_st_off: begin
          if (w_press) begin
            w_rail_nxt  = w_up_step;
            w_state_nxt = w_up_step[N_RAIL-1] ? c_st_on : c_st_up;
          end
        end
        c_st_up: begin
          if (arm_off_req) begin
            w_rail_nxt  = w_dn_step;
            w_state_nxt = (w_dn_step == '0) ? c_st_off : c_st_down;
          end else if (w_gap_hit) begin
            w_rail_nxt  = w_up_step;
            w_state_nxt = w_up_step[N_RAIL-1] ? c_st_on : c_st_up;
          end
        end
        c_st_on: begin
          if (arm_off_req || w_long_hit) begin
            w_rail_nxt  = w_dn_step;
            w_state_nxt = (w_dn_step == '0) ? c_st_off : c_st_down;
          end
        end
        c_st_down: begin
          if (w_gap_hit) begin
            w_rail_nxt  = w_dn_step;
            w_state_nxt = (w_dn_step == '0) ? c_st_off : c_st_down;
          end
        end
        c_st_fault: begin
          if (w_press && (&r_flt_s2)) begin
            w_state_nxt = c_st_off;
            w_latch_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = c_st_off;
          w_rail_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    seq_state = r_state;
    busy      = (r_state == c_st_up) || (r_state == c_st_down);
  end

endmodule
`default_nettype wire
